axil_cmd_master: RTL and testbench

- AXI4-Lite initiator (master) that turns a simple valid/ready command stream into single-beat AXI-Lite reads and writes.
- Used to drive CL register slaves, such as the hello-world/VLED register block, from internal logic, e.g. a self-test sequencer or a DMA-side register access path.
- One transaction outstanding at a time.
- Response wait is bounded by a programmable timeout.

---
 rtl/axil_cmd_master.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: turns a valid/ready command stream into single-beat AXI-Lite
// reads and writes, one outstanding, with a bounded response wait.
module axil_cmd_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_areset,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              busy,

  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WB    = 3'd2,
    S_RA    = 3'd3,
    S_RD    = 3'd4,
    S_RSP   = 3'd5,
    S_STALE = 3'd6
  } state_t;

  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               write_q, write_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               bready_q, bready_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_write_q, rsp_write_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic [1:0]         rsp_resp_q, rsp_resp_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               stale_q, stale_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, expired;

  assign aw_hs   = awvalid_q && m_axi_awready;
  assign w_hs    = wvalid_q  && m_axi_wready;
  assign b_hs    = bready_q  && m_axi_bvalid;
  assign ar_hs   = arvalid_q && m_axi_arready;
  assign r_hs    = rready_q  && m_axi_rvalid;
  assign expired = TIMEOUT_EN && (cnt_q == CNT_LAST);

  // State and output registers; every AXI and response output comes straight from here.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_q       <= S_IDLE;
      addr_q        <= {ADDR_W{1'b0}};
      wdata_q       <= 32'h0000_0000;
      wstrb_q       <= 4'h0;
      write_q       <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0000_0000;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      stale_q       <= 1'b0;
      cnt_q         <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      write_q       <= write_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      stale_q       <= stale_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    write_d       = write_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    stale_d       = stale_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          write_d = cmd_write;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RA;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        else       awvalid_d = awvalid_q;
        if (w_hs)  wvalid_d  = 1'b0;
        else       wvalid_d  = wvalid_q;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          cnt_d    = {CNT_W{1'b0}};
          state_d  = S_WB;
        end else begin
          state_d = S_WR;
        end
      end

      S_WB: begin
        rsp_write_d = 1'b1;
        rsp_rdata_d = 32'h0000_0000;
        // A B handshake on the expiry cycle takes priority over the timeout.
        if (b_hs) begin
          rsp_resp_d    = m_axi_bresp;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          bready_d      = 1'b0;
          state_d       = S_RSP;
        end else if (expired) begin
          rsp_resp_d    = 2'b10;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          stale_d       = 1'b1;
          state_d       = S_RSP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RA: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = {CNT_W{1'b0}};
          state_d   = S_RD;
        end else begin
          state_d = S_RA;
        end
      end

      S_RD: begin
        rsp_write_d = 1'b0;
        if (r_hs) begin
          rsp_rdata_d   = m_axi_rdata;
          rsp_resp_d    = m_axi_rresp;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          rready_d      = 1'b0;
          state_d       = S_RSP;
        end else if (expired) begin
          rsp_rdata_d   = TIMEOUT_RDATA;
          rsp_resp_d    = 2'b10;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          stale_d       = 1'b1;
          state_d       = S_RSP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RSP: begin
        // The late response may already arrive while the timeout response is held.
        if (stale_q && (b_hs || r_hs)) begin
          stale_d  = 1'b0;
          bready_d = 1'b0;
          rready_d = 1'b0;
        end else begin
          stale_d = stale_q;
        end
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = stale_d ? S_STALE : S_IDLE;
        end else begin
          state_d = S_RSP;
        end
      end

      S_STALE: begin
        if (b_hs || r_hs) begin
          stale_d  = 1'b0;
          bready_d = 1'b0;
          rready_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          state_d = S_STALE;
        end
      end

      default: begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        stale_d     = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);

  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a small hello-world style register slave
// (byte-swapped readback at 0x500, low half at 0x504) and an injectable late R beat.
module tb_axil_cmd_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int tests_run    = 0;
  int tests_failed = 0;

  axil_cmd_master #(
    .ADDR_W(32), .TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEAD_BEEF)
  ) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int          aw_delay = 0;
  logic        r_drop   = 1'b0;
  logic        inj_rvalid = 1'b0;
  logic [31:0] inj_rdata  = 32'h0;
  int          aw_cnt, aw_beats, w_beats, b_beats, ar_beats, aw_hi, w_hi, rsp_cnt;
  logic        got_aw, got_w, s_bvalid, s_rvalid;
  logic [31:0] aw_addr_l, w_data_l, reg500, s_rdata, last_awaddr, last_wdata;
  logic [3:0]  w_strb_l, last_wstrb;
  logic [1:0]  s_rresp;
  logic        aw_hs, w_hs, have_aw, have_w;
  logic [31:0] cur_addr, cur_data;
  logic [3:0]  cur_strb;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  assign awready = (aw_cnt >= aw_delay);
  assign wready  = 1'b1;
  assign arready = 1'b1;
  assign bresp   = 2'b00;
  assign bvalid  = s_bvalid;
  assign rvalid  = s_rvalid | inj_rvalid;
  assign rdata   = inj_rvalid ? inj_rdata : s_rdata;
  assign rresp   = inj_rvalid ? 2'b00 : s_rresp;

  always_comb begin
    aw_hs    = awvalid && awready;
    w_hs     = wvalid && wready;
    have_aw  = got_aw | aw_hs;
    have_w   = got_w | w_hs;
    cur_addr = aw_hs ? awaddr : aw_addr_l;
    cur_data = w_hs ? wdata : w_data_l;
    cur_strb = w_hs ? wstrb : w_strb_l;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      aw_addr_l <= 32'h0; w_data_l <= 32'h0; w_strb_l <= 4'h0; reg500 <= 32'h0;
      s_rdata <= 32'h0; s_rresp <= 2'b00;
    end else begin
      if (aw_hs) aw_cnt <= 0;
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (aw_hs) aw_addr_l <= awaddr;
      if (w_hs) begin w_data_l <= wdata; w_strb_l <= wstrb; end
      if (s_bvalid && bready) s_bvalid <= 1'b0;
      if (have_aw && have_w) begin
        got_aw <= 1'b0; got_w <= 1'b0; s_bvalid <= 1'b1;
        if (cur_addr == 32'h500) reg500 <= merge(reg500, cur_data, cur_strb);
      end else begin
        got_aw <= have_aw; got_w <= have_w;
      end
      if (s_rvalid && rready) s_rvalid <= 1'b0;
      if (arvalid && arready && !r_drop) begin
        s_rvalid <= 1'b1;
        case (araddr)
          32'h500: begin s_rdata <= swap(reg500); s_rresp <= 2'b00; end
          32'h504: begin s_rdata <= {16'h0000, reg500[15:0]}; s_rresp <= 2'b00; end
          default: begin s_rdata <= 32'h0; s_rresp <= 2'b11; end
        endcase
      end
    end
  end

  // Beat and activity counters used to check AXI traffic shape.
  always_ff @(posedge clk) begin
    if (aw_hs) begin aw_beats <= aw_beats + 1; last_awaddr <= awaddr; end
    if (w_hs)  begin w_beats <= w_beats + 1; last_wdata <= wdata; last_wstrb <= wstrb; end
    if (bvalid && bready) b_beats <= b_beats + 1;
    if (arvalid && arready) ar_beats <= ar_beats + 1;
    if (awvalid) aw_hi <= aw_hi + 1;
    if (wvalid) w_hi <= w_hi + 1;
    if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge (cycle 2).
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int n;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("accept_wait", 32'd0, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Cycle index counts the accept cycle as 1.
  task automatic wait_rsp(output int cyc);
    cyc = 2;
    while (!rsp_valid && cyc < 60) begin @(negedge clk); cyc++; end
    if (!rsp_valid) check("rsp_wait", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int          cyc, snap_a, snap_b, snap_c, snap_d;
  logic [31:0] exp_reg, d;
  logic [3:0]  s;
  logic        stable;

  initial begin
    aw_beats = 0; w_beats = 0; b_beats = 0; ar_beats = 0; aw_hi = 0; w_hi = 0; rsp_cnt = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_readies", {30'd0, bready, rready}, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", awaddr | araddr, 32'd0);
    check("rst_prot", {26'd0, awprot, arprot}, 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero-wait write
    snap_a = aw_beats; snap_b = w_beats;
    issue(1'b1, 32'h500, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(cyc);
    check("wr_latency", 32'(cyc), 32'd4);
    check("wr_rsp_write", 32'(rsp_write), 32'd1);
    check("wr_rsp_resp", 32'(rsp_resp), 32'd0);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    check("wr_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("wr_awaddr", last_awaddr, 32'h500);
    check("wr_wdata", last_wdata, 32'hDEAD_BEEF);
    check("wr_wstrb", 32'(last_wstrb), 32'hF);
    check("wr_beats", 32'((aw_beats - snap_a) * 16 + (w_beats - snap_b)), 32'h11);
    @(negedge clk);
    exp_reg = 32'hDEAD_BEEF;

    // 2: reads
    issue(1'b0, 32'h500, 32'h0, 4'h0);
    wait_rsp(cyc);
    check("rd_latency", 32'(cyc), 32'd4);
    check("rd500_data", rsp_rdata, 32'hEFBE_ADDE);
    check("rd500_resp", 32'(rsp_resp), 32'd0);
    check("rd500_write", 32'(rsp_write), 32'd0);
    @(negedge clk);
    issue(1'b0, 32'h504, 32'h0, 4'h0);
    wait_rsp(cyc);
    check("rd504_data", rsp_rdata, 32'h0000_BEEF);
    @(negedge clk);
    issue(1'b0, 32'h600, 32'h0, 4'h0);
    wait_rsp(cyc);
    check("rd600_resp", 32'(rsp_resp), 32'd3);
    @(negedge clk);

    // 3: awready delayed, wready immediate
    aw_delay = 4;
    snap_a = aw_hi; snap_b = w_hi; snap_c = b_beats; snap_d = rsp_cnt;
    issue(1'b1, 32'h500, 32'h1122_3344, 4'b0011);
    wait_rsp(cyc);
    check("awdly_latency", 32'(cyc), 32'd8);
    repeat (4) @(negedge clk);
    check("awdly_aw_cycles", 32'(aw_hi - snap_a), 32'd5);
    check("awdly_w_cycles", 32'(w_hi - snap_b), 32'd1);
    check("awdly_b_beats", 32'(b_beats - snap_c), 32'd1);
    check("awdly_rsp_count", 32'(rsp_cnt - snap_d), 32'd1);
    aw_delay = 0;
    exp_reg = 32'hDEAD_3344;

    // 4: read timeout, then stale until a late R arrives
    r_drop = 1'b1;
    issue(1'b0, 32'h504, 32'h0, 4'h0);
    wait_rsp(cyc);
    check("to_latency", 32'(cyc), 32'd11);
    check("to_flag", 32'(rsp_timeout), 32'd1);
    check("to_resp", 32'(rsp_resp), 32'd2);
    check("to_rdata", rsp_rdata, 32'hDEAD_BEEF);
    repeat (5) @(negedge clk);
    check("stale_cmd_ready", 32'(cmd_ready), 32'd0);
    check("stale_rready", 32'(rready), 32'd1);
    check("stale_busy", 32'(busy), 32'd1);
    inj_rdata = 32'h1234_5678; inj_rvalid = 1'b1;
    @(negedge clk);
    inj_rvalid = 1'b0;
    check("stale_exit_cmd_ready", 32'(cmd_ready), 32'd1);
    check("stale_exit_rready", 32'(rready), 32'd0);

    // 4b: R on the expiry cycle beats the timeout
    issue(1'b0, 32'h500, 32'h0, 4'h0);
    repeat (8) @(negedge clk);
    inj_rdata = 32'hCAFE_F00D; inj_rvalid = 1'b1;
    @(negedge clk);
    inj_rvalid = 1'b0;
    check("edge_rsp_valid", 32'(rsp_valid), 32'd1);
    check("edge_timeout", 32'(rsp_timeout), 32'd0);
    check("edge_rdata", rsp_rdata, 32'hCAFE_F00D);
    check("edge_resp", 32'(rsp_resp), 32'd0);
    @(negedge clk);
    check("edge_idle", 32'(cmd_ready), 32'd1);
    r_drop = 1'b0;
    issue(1'b0, 32'h500, 32'h0, 4'h0);
    wait_rsp(cyc);
    check("post_stale_rdata", rsp_rdata, 32'h4433_ADDE);
    @(negedge clk);

    // 5a: response back-pressure
    rsp_ready = 1'b0;
    snap_a = aw_beats + w_beats + ar_beats;
    issue(1'b1, 32'h504, 32'hFFFF_0000, 4'hF);
    wait_rsp(cyc);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h500;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stable &= rsp_valid && rsp_write && (rsp_resp == 2'b00) && (rsp_rdata == 32'h0)
                && !rsp_timeout && !cmd_ready;
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_no_traffic", 32'(aw_beats + w_beats + ar_beats - snap_a), 32'd2);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {30'd0, rsp_valid, cmd_ready}, 32'd1);

    // 5b: 20 mixed commands, in-order scoreboard
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        d = 32'h0101_0101 * i ^ 32'hA5A5_0F0F;
        s = 4'(i);
        issue(1'b1, 32'h500, d, s);
        wait_rsp(cyc);
        exp_reg = merge(exp_reg, d, s);
        check($sformatf("mix%0d_wr", i), {rsp_rdata[29:0], rsp_resp}, 32'd0);
      end else begin
        issue(1'b0, 32'h500, 32'h0, 4'h0);
        wait_rsp(cyc);
        check($sformatf("mix%0d_rd", i), rsp_rdata, swap(exp_reg));
      end
      @(negedge clk);
    end

    // 6: reset in the middle of WR
    aw_delay = 20;
    issue(1'b1, 32'h500, 32'h0BAD_F00D, 4'hF);
    check("mid_wr_awvalid", 32'(awvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valids", {30'd0, awvalid, wvalid}, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0; aw_delay = 0;
    @(negedge clk);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    issue(1'b0, 32'h500, 32'h0, 4'h0);
    wait_rsp(cyc);
    check("arst_read", rsp_rdata, 32'h0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
